instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream neighbour of the instruction decoder. Holds the PC and fetches one word per instruction from imem (valid/ready request, variable-latency response).
//  Presents instruction + PC to the decoder over a valid/ready handshake. Applies branch/jump/jr redirects computed from decoder fields (immediate, address).
// PARAMETERS
//  RESET_PC          32'h0000_0000  PC loaded on reset; first fetch address
//  JUMP_REGION_BITS  4              upper bits of PC+4 kept by j/jal target
// PORTS
//  clk             in   1   single clock, rising edge
//  reset           in   1   asynchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request
//  imem_addr       out  32  fetch address (== pc)
//  imem_rsp_valid  in   1   response data valid (one per accepted request)
//  imem_rsp_data   in   32  fetched word
//  instr_valid     out  1   instruction buffer valid to decoder
//  instr_ready     in   1   decoder consumes instruction
//  instruction     out  32  buffered instruction word
//  instr_pc        out  32  PC of buffered instruction
//  pc_plus4        out  32  instr_pc + 4 (jal link value)
//  redirect_valid  in   1   control-flow change for the instruction consumed this cycle
//  redirect_kind   in   2   0=branch, 1=j/jal, 2=jr, 3=reserved (treated as no redirect)
//  branch_imm      in   16  decoder immediate
//  jump_addr       in   26  decoder address field
//  jr_target       in   32  register value for jr
// BEHAVIOUR
//  Reset (async): state=S_IDLE, pc=RESET_PC, imem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0, pc_plus4=0; imem_addr=pc.
//  FSM states S_IDLE, S_REQ, S_WAIT, S_HOLD (+S_FAULT, macro only):
//   S_IDLE: unconditionally -> S_REQ next cycle (first request 1 cycle after reset release).
//   S_REQ : imem_req_valid=1; on imem_req_ready -> S_WAIT. pc and imem_addr stable while waiting.
//   S_WAIT: imem_req_valid=0; on imem_rsp_valid: instruction<=rsp_data, instr_pc<=pc, pc_plus4<=pc+4 -> S_HOLD.
//   S_HOLD: instr_valid=1, outputs stable until instr_valid&&instr_ready; then -> S_REQ, pc<=next.
//  Latency: response -> instr_valid next cycle (registered). Min 3 cycles/instruction; no back-to-back requests.
//  next pc at consume: redirect_valid ? target : instr_pc+4. Targets (mod 2^32, wrap silently):
//   branch: instr_pc + 4 + (sext(branch_imm) << 2)
//   j/jal : {pc_plus4[31:32-JUMP_REGION_BITS], jump_addr, 2'b00}
//   jr    : jr_target
//  redirect_valid is sampled only in the cycle of instr_valid&&instr_ready; ignored in every other cycle.
//  imem_rsp_valid outside S_WAIT is ignored (protocol error, no state change).
//  pc = 32'hFFFF_FFFC consumed without redirect: next pc wraps to 0.
//  Reset mid-transaction: in-flight request abandoned; any late response arrives in S_IDLE/S_REQ and is ignored.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: adds output fetch_misaligned (1 bit, reset 0). A redirect target with [1:0]!=0 goes to S_FAULT:
//   fetch_misaligned=1, pc=target, no requests, instr_valid=0 until reset.
//  Undefined: no port, no S_FAULT; target[1:0] forced to 2'b00.
// STRUCTURE
//  Shared package fetch_pkg: redirect kind constants (RK_BRANCH, RK_JUMP, RK_JR), FSM state encoding, WORD_BYTES=4.
//  Sub-module pc_next_calc (combinational): instr_pc, pc_plus4, redirect fields -> next pc (+ misaligned flag). FSM and registers stay in top.
// TESTING
//  1 Reset release, RESET_PC=0, imem ready=1, 1-cycle rsp -> req addr 0 at cycle 1; instr_valid at cycle 3 with instr_pc=0, pc_plus4=4.
//  2 Sequential, decoder ready=1 -> addresses 0,4,8,C in order; each instruction held until consumed; ready=0 for 5 cycles keeps outputs stable.
//  3 Branch at pc 0x10, imm=16'hFFFE -> next imem_addr 0x0C; imm=16'h0003 -> 0x20.
//  4 j at pc 0x4000_0010, jump_addr=26'h000_0040 -> next addr 0x4000_0100; jr jr_target=0x1234 -> 0x1234.
//  5 imem_req_ready low 4 cycles, rsp delay 3 cycles; redirect pulsed while instr_valid=0 -> no effect on addresses.
//  6 Reset asserted in S_WAIT, stray rsp after release -> discarded; fetch restarts at RESET_PC. With FETCH_ALIGN_CHECK_EN, jr 0x1236 -> fetch_misaligned=1, no further requests.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: redirect kinds, FSM states, word size.
// FETCH_ALIGN_CHECK_EN adds the S_FAULT state used for misaligned redirect targets.
package fetch_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [1:0] RK_BRANCH = 2'd0;
   localparam logic [1:0] RK_JUMP   = 2'd1;
   localparam logic [1:0] RK_JR     = 2'd2;

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_t;
`endif

   // Branch immediates count words, so the byte offset is the sign-extended value times four.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for a consumed instruction (fall-through or redirect target).
// With FETCH_ALIGN_CHECK_EN the raw target is passed through and flagged; otherwise it is word-aligned.
module pc_next_calc
   import fetch_pkg::*;
#(
   parameter int JUMP_REGION_BITS = 4
) (
   input  logic [31:0] instr_pc,
   input  logic [31:0] pc_plus4,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_kind,
   input  logic [15:0] branch_imm,
   input  logic [25:0] jump_addr,
   input  logic [31:0] jr_target,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misaligned,
`endif
   output logic [31:0] next_pc
);

   // j/jal keeps the top JUMP_REGION_BITS of pc_plus4 and fills the rest from the address field.
   localparam logic [31:0] REGION_MASK = ~((32'h1 << (32 - JUMP_REGION_BITS)) - 32'h1);

   logic [31:0] target;
   logic        taken;

   always_comb begin
      target = pc_plus4;
      taken  = 1'b0;
      if (redirect_valid) begin
         case (redirect_kind)
            RK_BRANCH: begin
               target = instr_pc + 32'(WORD_BYTES) + branch_offset(branch_imm);
               taken  = 1'b1;
            end
            RK_JUMP: begin
               target = (pc_plus4 & REGION_MASK) | ({4'b0000, jump_addr, 2'b00} & ~REGION_MASK);
               taken  = 1'b1;
            end
            RK_JR: begin
               target = jr_target;
               taken  = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = taken && (target[1:0] != 2'b00);
   assign next_pc    = target;
`else
   assign next_pc    = taken ? (target & 32'hFFFF_FFFC) : target;
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: holds the PC, issues one imem request per instruction and buffers it for the decoder.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_misaligned and a sticky fault state.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          JUMP_REGION_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        fetch_misaligned,
`endif
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_kind,
   input  logic [15:0] branch_imm,
   input  logic [25:0] jump_addr,
   input  logic [31:0] jr_target
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic         misaligned;
`endif

   assign imem_addr = pc;

   pc_next_calc #(
      .JUMP_REGION_BITS(JUMP_REGION_BITS)
   ) u_pc_next_calc (
      .instr_pc       (instr_pc),
      .pc_plus4       (pc_plus4),
      .redirect_valid (redirect_valid),
      .redirect_kind  (redirect_kind),
      .branch_imm     (branch_imm),
      .jump_addr      (jump_addr),
      .jr_target      (jr_target),
`ifdef FETCH_ALIGN_CHECK_EN
      .misaligned     (misaligned),
`endif
      .next_pc        (next_pc)
   );

   // One request in flight at most; the PC only advances when the decoder takes the buffered word,
   // so responses seen outside S_WAIT (e.g. after a reset abandoned a request) fall on the floor.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         imem_req_valid <= 1'b0;
         instr_valid    <= 1'b0;
         instruction    <= 32'h0;
         instr_pc       <= 32'h0;
         pc_plus4       <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_misaligned <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state          <= S_REQ;
               imem_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (imem_req_ready) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  instruction <= imem_rsp_data;
                  instr_pc    <= pc;
                  pc_plus4    <= pc + 32'(WORD_BYTES);
                  instr_valid <= 1'b1;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  pc          <= next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                  if (misaligned) begin
                     state            <= S_FAULT;
                     fetch_misaligned <= 1'b1;
                  end else
`endif
                  begin
                     state          <= S_REQ;
                     imem_req_valid <= 1'b1;
                  end
               end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: ;
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: imem responder, PC-sequence model, directed scenarios.
// Build with FETCH_ALIGN_CHECK_EN to exercise the misaligned-fault path.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif
   logic        redirect_valid;
   logic [1:0]  redirect_kind;
   logic [15:0] branch_imm;
   logic [25:0] jump_addr;
   logic [31:0] jr_target;

   int checks    = 0;
   int failures  = 0;
   int rsp_delay = 1;
   int req_stall = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .RESET_PC         (RESET_PC),
      .JUMP_REGION_BITS (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .pc_plus4       (pc_plus4),
`ifdef FETCH_ALIGN_CHECK_EN
      .fetch_misaligned (fetch_misaligned),
`endif
      .redirect_valid (redirect_valid),
      .redirect_kind  (redirect_kind),
      .branch_imm     (branch_imm),
      .jump_addr      (jump_addr),
      .jr_target      (jr_target)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Instruction memory: ready after req_stall cycles of a pending request, data rsp_delay cycles later.
   initial begin : imem_responder
      logic        acc, rv;
      logic [31:0] a, la;
      int          cnt, waitc;
      cnt = -1;
      waitc = 0;
      la = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = (req_stall == 0);
      forever begin
         @(negedge clk);
         acc = imem_req_valid && imem_req_ready;
         rv  = imem_req_valid;
         a   = imem_addr;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (acc) begin
            cnt = rsp_delay;
            la = a;
            waitc = 0;
         end else if (rv) begin
            waitc++;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(la);
               cnt = -1;
            end
         end
         imem_req_ready = (waitc >= req_stall);
      end
   end

   // Architectural model: where the next fetch must go, given the consumed instruction's PC.
   function automatic logic [31:0] model_target(input logic [31:0] ipc, input logic rv,
                                                input logic [1:0] kind, input logic [15:0] imm,
                                                input logic [25:0] ja, input logic [31:0] jt);
      if (!rv || kind == 2'd3) return ipc + 4;
      case (kind)
         2'd0:    return ipc + 4 + 32'(int'($signed(imm)) * 4);
         2'd1:    return ((ipc + 4) & 32'hF000_0000) + 32'(ja) * 4;
         default: return jt;
      endcase
   endfunction

   logic [31:0] m_pc, m_fa, m_data, m_ipc, m_t;
   logic        m_out, m_pend, m_hold, m_idle, m_fault;

   always @(negedge clk) begin
      if (reset) begin
         m_pc = RESET_PC; m_out = 0; m_pend = 0; m_hold = 0; m_idle = 1; m_fault = 0;
         checkBit("rst_req_valid", imem_req_valid, 1'b0);
         checkBit("rst_instr_valid", instr_valid, 1'b0);
         checkOutput("rst_imem_addr", imem_addr, RESET_PC);
         checkOutput("rst_instruction", instruction, 32'h0);
         checkOutput("rst_instr_pc", instr_pc, 32'h0);
         checkOutput("rst_pc_plus4", pc_plus4, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
         checkBit("rst_misaligned", fetch_misaligned, 1'b0);
`endif
      end else begin
         if (m_pend) begin
            m_hold = 1;
            m_pend = 0;
         end
         checkBit("req_valid", imem_req_valid, !(m_idle || m_out || m_hold || m_fault));
         checkBit("instr_valid", instr_valid, m_hold);
         checkOutput("imem_addr", imem_addr, m_pc);
         if (m_hold) begin
            checkOutput("instruction", instruction, mem_word(m_ipc));
            checkOutput("instr_pc", instr_pc, m_ipc);
            checkOutput("pc_plus4", pc_plus4, m_ipc + 4);
         end
`ifdef FETCH_ALIGN_CHECK_EN
         checkBit("misaligned", fetch_misaligned, m_fault);
`endif
         m_idle = 0;
         if (m_out && imem_rsp_valid) begin
            m_out = 0; m_pend = 1; m_data = imem_rsp_data; m_ipc = m_fa;
         end else if (!m_fault && imem_req_valid && imem_req_ready) begin
            m_out = 1; m_fa = m_pc;
         end
         if (m_hold && instr_valid && instr_ready) begin
            m_hold = 0;
            m_t = model_target(m_ipc, redirect_valid, redirect_kind, branch_imm, jump_addr, jr_target);
`ifdef FETCH_ALIGN_CHECK_EN
            m_fault = (m_t[1:0] != 2'b00);
            m_pc = m_t;
`else
            m_pc = m_t & 32'hFFFF_FFFC;
`endif
         end
      end
   end

   task automatic waitValid();
      for (int i = 0; i < 100 && !instr_valid; i++) step();
      checkBit("wait_instr_valid", instr_valid, 1'b1);
   endtask

   task automatic expectAddr(input string name, input logic [31:0] exp);
      for (int i = 0; i < 100 && !imem_req_valid; i++) step();
      checkBit({name, "_v"}, imem_req_valid, 1'b1);
      checkOutput(name, imem_addr, exp);
   endtask

   // Wait for a buffered instruction and consume it with the given redirect fields.
   task automatic applyStimulus(input logic rv, input logic [1:0] kind, input logic [15:0] imm,
                                input logic [25:0] ja, input logic [31:0] jt);
      waitValid();
      redirect_valid = rv;
      redirect_kind  = kind;
      branch_imm     = imm;
      jump_addr      = ja;
      jr_target      = jt;
      instr_ready    = 1'b1;
      step();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'd0;
      branch_imm = 16'h0; jump_addr = 26'h0; jr_target = 32'h0;
      repeat (3) step();
      reset = 1'b0;

      checkBit("t1_idle_no_req", imem_req_valid, 1'b0);
      step();
      checkBit("t1_req_c1", imem_req_valid, 1'b1);
      checkOutput("t1_addr_c1", imem_addr, 32'h0);
      step();
      checkBit("t1_iv_c2", instr_valid, 1'b0);
      step();
      checkBit("t1_iv_c3", instr_valid, 1'b1);
      checkOutput("t1_instr_pc", instr_pc, 32'h0);
      checkOutput("t1_pc_plus4", pc_plus4, 32'h4);
      checkOutput("t1_instruction", instruction, 32'hDEAD_BEEF);

      instr_ready = 1'b1;
      for (int i = 0; i < 100 && !(imem_req_valid && imem_addr == 32'hC); i++) step();
      instr_ready = 1'b0;
      checkOutput("t2_reach_c", imem_addr, 32'hC);
      waitValid();
      repeat (5) step();
      checkBit("t2_hold_valid", instr_valid, 1'b1);
      checkOutput("t2_hold_pc", instr_pc, 32'hC);
      checkOutput("t2_hold_instr", instruction, 32'hDEAD_BEE3);

      applyStimulus(1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
      expectAddr("t2_seq_10", 32'h10);
      applyStimulus(1'b1, 2'd0, 16'hFFFE, 26'h0, 32'h0);
      expectAddr("t3_branch_back", 32'h0C);
      applyStimulus(1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
      expectAddr("t3_seq_10b", 32'h10);
      applyStimulus(1'b1, 2'd0, 16'h0003, 26'h0, 32'h0);
      expectAddr("t3_branch_fwd", 32'h20);
      applyStimulus(1'b1, 2'd2, 16'h0, 26'h0, 32'h4000_0010);
      expectAddr("t4_jr_region", 32'h4000_0010);
      applyStimulus(1'b1, 2'd1, 16'h0, 26'h000_0040, 32'h0);
      expectAddr("t4_jump", 32'h4000_0100);
      applyStimulus(1'b1, 2'd2, 16'h0, 26'h0, 32'h0000_1234);
      expectAddr("t4_jr", 32'h0000_1234);
      applyStimulus(1'b1, 2'd3, 16'h0, 26'h0, 32'h0000_9990);
      expectAddr("t4_reserved", 32'h0000_1238);
      applyStimulus(1'b1, 2'd2, 16'h0, 26'h0, 32'hFFFF_FFFC);
      expectAddr("t4_jr_top", 32'hFFFF_FFFC);
      waitValid();
      checkOutput("t4_wrap_plus4", pc_plus4, 32'h0);
      applyStimulus(1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
      expectAddr("t4_wrap", 32'h0);

      req_stall = 4;
      rsp_delay = 3;
      applyStimulus(1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
      expectAddr("t5_seq_4", 32'h4);
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_kind = 2'd2; jr_target = 32'h8888;
      repeat (6) step();
      checkOutput("t5_pulse_ignored", imem_addr, 32'h4);
      instr_ready = 1'b0; redirect_valid = 1'b0;
      applyStimulus(1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
      expectAddr("t5_seq_8", 32'h8);

      req_stall = 0;
      for (int i = 0; i < 100 && imem_req_valid; i++) step();
      checkBit("t6_in_wait", imem_req_valid, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      expectAddr("t6_restart", RESET_PC);
      waitValid();
      checkOutput("t6_instr", instruction, 32'hDEAD_BEEF);
      checkOutput("t6_instr_pc", instr_pc, RESET_PC);

      applyStimulus(1'b1, 2'd2, 16'h0, 26'h0, 32'h0000_1236);
`ifdef FETCH_ALIGN_CHECK_EN
      checkBit("t6_misaligned", fetch_misaligned, 1'b1);
      repeat (10) step();
      checkBit("t6_fault_no_req", imem_req_valid, 1'b0);
      checkBit("t6_fault_no_instr", instr_valid, 1'b0);
      checkOutput("t6_fault_pc", imem_addr, 32'h0000_1236);
`else
      expectAddr("t6_jr_aligned", 32'h0000_1234);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
